// File: rtl/sysid_boot_checker.sv
// sysid_boot_checker: reads system-ID and timestamp words over Avalon-MM and publishes a sticky boot verdict
module sysid_boot_checker #(
  parameter logic [31:0] EXP_ID = 32'h0,
  parameter logic [31:0] EXP_TS = 32'd1545046410,
  parameter int READ_LATENCY = 0,
  parameter int TIMEOUT = 255,
  parameter int RETRIES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        av_address,
  output logic        av_read,
  input  logic        av_waitrequest,
  input  logic [31:0] av_readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [1:0]  err_code,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);
  typedef enum logic [2:0] {IDLE, RD_ID, LAT_ID, RD_TS, LAT_TS, EVAL} state_t;
  state_t state, state_n;
  logic armed, wait_to, done_n, pass_n;
  logic [1:0] retry_cnt, retry_n, err_n;
  logic [7:0] tmo_cnt, tmo_n;
  logic [31:0] id_n, ts_n;
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= RD_ID;
      armed <= 1'b0;
      retry_cnt <= 2'd0;
      tmo_cnt <= 8'd0;
      done <= 1'b0;
      pass <= 1'b0;
      err_code <= 2'd0;
      id_value <= 32'd0;
      ts_value <= 32'd0;
    end else begin
      armed <= 1'b1;
      if (armed) begin
        state <= state_n;
        retry_cnt <= retry_n;
        tmo_cnt <= tmo_n;
        done <= done_n;
        pass <= pass_n;
        err_code <= err_n;
        id_value <= id_n;
        ts_value <= ts_n;
      end
    end
  end
  assign av_read = armed && (state == RD_ID || state == RD_TS);
  assign av_address = armed && state == RD_TS;
  assign busy = armed && state != IDLE;
  assign wait_to = av_waitrequest && tmo_cnt == 8'(TIMEOUT - 1);
  always_comb begin
    state_n = state;
    retry_n = retry_cnt;
    tmo_n = tmo_cnt;
    done_n = done;
    pass_n = pass;
    err_n = err_code;
    id_n = id_value;
    ts_n = ts_value;
    case (state)
      IDLE: if (start) begin
        state_n = RD_ID;
        retry_n = 2'd0;
        done_n = 1'b0;
        pass_n = 1'b0;
        err_n = 2'd0;
      end
      RD_ID, RD_TS: begin
        tmo_n = av_waitrequest && !wait_to ? tmo_cnt + 8'd1 : 8'd0;
        if (wait_to) begin
          err_n = 2'd3;
          state_n = EVAL;
        end else if (!av_waitrequest) begin
          if (READ_LATENCY == 0 && state == RD_ID) id_n = av_readdata;
          if (READ_LATENCY == 0 && state == RD_TS) ts_n = av_readdata;
          state_n = READ_LATENCY != 0 ? (state == RD_ID ? LAT_ID : LAT_TS)
                                      : (state == RD_ID ? RD_TS : EVAL);
        end
      end
      LAT_ID: begin
        id_n = av_readdata;
        state_n = RD_TS;
      end
      LAT_TS: begin
        ts_n = av_readdata;
        state_n = EVAL;
      end
      EVAL: begin
        if (err_code != 2'd3 && id_value == EXP_ID && ts_value == EXP_TS) begin
          done_n = 1'b1;
          pass_n = 1'b1;
          err_n = 2'd0;
          state_n = IDLE;
        end else if (retry_cnt < 2'(RETRIES)) begin
          retry_n = retry_cnt + 2'd1;
          err_n = 2'd0;
          state_n = RD_ID;
        end else begin
          done_n = 1'b1;
          pass_n = 1'b0;
          err_n = err_code == 2'd3 ? 2'd3 : id_value != EXP_ID ? 2'd1 : 2'd2;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: doc/sysid_boot_checker.md
Name: sysid_boot_checker

Overview:
- Avalon-MM read master that sits directly upstream of the system-ID slave and consumes what it returns.
- After reset, or on a start pulse, it reads word 0 (system ID) and word 1 (build timestamp) and compares both against expected parameters.
- It then publishes a sticky pass/fail verdict that boot logic uses to release the CPU from hold.
- Bounded waitrequest timeout and limited retry.

Parameters:
EXP_ID, 32'h0, expected value at address 0
EXP_TS, 32'd1545046410, expected value at address 1
READ_LATENCY, 0, fixed slave read latency in cycles (legal 0 or 1)
TIMEOUT, 255, max cycles read may be held with waitrequest high (1..255)
RETRIES, 2, extra full read passes after a mismatch/timeout (0..3)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  single-cycle pulse: rerun check (ignored while busy)
av_address  out  1  slave word address (0 = ID, 1 = timestamp)
av_read  out  1  read request
av_waitrequest  in  1  slave stall; tie 0 for zero-wait slave
av_readdata  in  32  slave read data
busy  out  1  check in progress
done  out  1  verdict valid (sticky until next run)
pass  out  1  both words matched (valid when done)
err_code  out  2  0 none, 1 ID mismatch, 2 TS mismatch, 3 timeout
id_value  out  32  last captured ID word
ts_value  out  32  last captured timestamp word

Behaviour:
- Reset (sync, clock edge with reset=1): state ← RD_ID, retry_cnt ← 0, tmo_cnt ← 0. Outputs: av_read=0, av_address=0, done=0, pass=0, err_code=0, id_value=0, ts_value=0. busy=1 from the first cycle after reset deassertion. Reset mid-transaction aborts it; no capture occurs.
- States: IDLE, RD_ID, LAT_ID, RD_TS, LAT_TS, EVAL.
- IDLE: busy=0, av_read=0. start=1 → clear done/pass/err_code, retry_cnt ← 0, go RD_ID.
- RD_ID / RD_TS: av_read=1; av_address = 0 / 1. Both held stable while av_waitrequest=1.
  - Accept = cycle with av_read=1 and av_waitrequest=0.
  - READ_LATENCY=0: capture av_readdata in the accept cycle, then go to the next read (or EVAL).
  - READ_LATENCY=1: deassert av_read, go to LAT_x, capture av_readdata there one cycle later.
- tmo_cnt: increments each cycle av_waitrequest=1 during a read state and clears on accept. On reaching TIMEOUT: drop av_read, latch err_code=3, go EVAL. The last word is not captured.
- EVAL (one cycle):
  - Mismatch precedence: timeout > ID mismatch > TS mismatch.
  - id_value == EXP_ID and ts_value == EXP_TS and no timeout → pass=1, done=1, err_code=0, go IDLE.
  - Else if retry_cnt < RETRIES → retry_cnt+1, clear err_code, go RD_ID.
  - Else done=1, pass=0, err_code latched, go IDLE.
- Latency, zero-wait slave, READ_LATENCY=0: reset release at cycle 0 → ID read cycle 1, TS read cycle 2, EVAL cycle 3, done=1 visible cycle 4.
- start during busy is ignored. start coinciding with reset: reset wins.
- No pipelining: never more than one outstanding read.
- av_read is never asserted in IDLE or EVAL.

Test Plan:
- Zero-wait slave returning 0 / 1545046410, READ_LATENCY=0 → reads at addr 0 then 1 on cycles 1–2; done=1, pass=1, err_code=0 by cycle 4; id_value=0, ts_value=1545046410.
- Slave returns ID=0x12345678, RETRIES=2 → exactly 3 full read passes (6 accepts); final done=1, pass=0, err_code=1, id_value=0x12345678.
- av_waitrequest held high 3 cycles on the TS read → av_address=1 and av_read stable throughout; accept on 4th cycle; pass=1.
- av_waitrequest stuck high, TIMEOUT=8, RETRIES=0 → av_read drops after 8 wait cycles; done=1, err_code=3, busy=0.
- READ_LATENCY=1 with data presented one cycle after accept → correct capture and pass=1; then a start pulse clears done/pass the next cycle and reruns.
- reset asserted while in RD_TS → next cycle all outputs at reset values; fresh check restarts at addr 0 after release; start during busy has no effect.
